// File: rtl/pdp8_trace_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_trace_pkg
// Shared constants for the PDP-8 instruction-trace port:
//   - ASCII characters used in the trace line
//   - line length and character offsets of each octal field
//   - bit positions of the fields inside a 38-bit snapshot {pc,ir,l,ac,ion}
//   - FSM state encodings
//   - helper turning a 3-bit octal digit into its ASCII character
// ---------------------------------------------------------------------------
package pdp8_trace_pkg;

    localparam int SNAP_W   = 38;
    localparam int LINE_LEN = 35;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_0  = 8'h30;

    // Snapshot layout: pc[37:26] ir[25:14] l[13] ac[12:1] ion[0]
    localparam int PC_LSB  = 26;
    localparam int IR_LSB  = 14;
    localparam int L_BIT   = 13;
    localparam int AC_LSB  = 1;
    localparam int ION_BIT = 0;

    // Character offsets within "pc DDDD ir DDDD l D ac DDDD ion D\r\n"
    localparam logic [5:0] OFS_PC   = 6'd3;
    localparam logic [5:0] OFS_IR   = 6'd11;
    localparam logic [5:0] OFS_L    = 6'd18;
    localparam logic [5:0] OFS_AC   = 6'd23;
    localparam logic [5:0] OFS_ION  = 6'd32;
    localparam logic [5:0] OFS_CR   = 6'd33;
    localparam logic [5:0] OFS_LF   = 6'd34;
    localparam logic [5:0] LAST_IDX = 6'(LINE_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    function automatic logic [7:0] oct_char(input logic [2:0] d);
        return CH_0 + {5'd0, d};
    endfunction

endpackage

// File: rtl/pdp8_trace_if.sv
// ---------------------------------------------------------------------------
// pdp8_trace_if
// Byte-wide valid/ready link from the trace port to a UART transmitter.
//   tx_data   8  ASCII character
//   tx_valid  1  tx_data valid
//   tx_ready  1  transmitter accepts tx_data this cycle
// master = trace port (drives data/valid), slave = UART (drives ready).
// ---------------------------------------------------------------------------
interface pdp8_trace_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/pdp8_trace_fifo.sv
// ---------------------------------------------------------------------------
// pdp8_trace_fifo
// Synchronous FIFO holding trace snapshots.
//   clk, reset_n   clock, async active-low reset (pointers/count only)
//   i_push/i_wdata write request; accepted when not full, or when full and
//                  a pop happens in the same cycle
//   i_pop/o_rdata  read request; o_rdata always shows the head entry
//   o_full/o_empty occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module pdp8_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign w_pop_ok  = i_pop && !o_empty;
    // When full, the slot being written is the one being read this cycle;
    // the read sees the old contents before the edge, so this is safe.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_rdata   = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + 1'b1;
            end
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
        end
    end

endmodule

// File: rtl/pdp8_trace.sv
// ---------------------------------------------------------------------------
// pdp8_trace
// Instruction-trace port for the PDP-8 core. Each enabled fetch strobe
// captures {pc,ir,l,ac,ion} into a FIFO; the FSM turns each entry into the
// 35-character line "pc DDDD ir DDDD l D ac DDDD ion D\r\n" on a byte-wide
// valid/ready link to a UART transmitter.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   enable              capture enable, sampled with fetch_strobe
//   fetch_strobe        1-cycle pulse when the cpu is in fetch
//   pc, ir, l, ac, ion  cpu state captured at fetch
//   tx                  UART link (master side: tx_data, tx_valid / tx_ready)
//   drop_count          snapshots lost to a full FIFO, saturating
//   clear_drops         synchronous clear of drop_count
//   busy                FIFO non-empty or a line in progress
//
// state | meaning
// IDLE  | nothing to send, waiting for a FIFO entry
// LOAD  | pop FIFO head into hold register, restart char index (gap cycle)
// EMIT  | present char[index] with tx_valid, advance on acceptance
// ---------------------------------------------------------------------------
module pdp8_trace
    import pdp8_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              fetch_strobe,
    input  logic [11:0]       pc,
    input  logic [11:0]       ir,
    input  logic              l,
    input  logic [11:0]       ac,
    input  logic              ion,
    pdp8_trace_if.master      tx,
    output logic [DROP_W-1:0] drop_count,
    input  logic              clear_drops,
    output logic              busy
);

    logic [1:0]        r_state;
    logic [5:0]        r_idx;
    logic [SNAP_W-1:0] r_hold;
    logic [DROP_W-1:0] r_drop;

    logic              w_cap;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic              w_accept;
    logic              w_last;
    logic [SNAP_W-1:0] w_snap;
    logic [SNAP_W-1:0] w_head;
    logic [7:0]        w_char;
    logic [11:0]       w_pc;
    logic [11:0]       w_ir;
    logic [11:0]       w_ac;
    logic              w_l;
    logic              w_ion;

    assign w_cap  = fetch_strobe && enable;
    assign w_snap = {pc, ir, l, ac, ion};
    // LOAD is only entered with a non-empty FIFO, so this pop always succeeds.
    assign w_pop  = (r_state == ST_LOAD);
    assign w_drop = w_cap && w_full && !w_pop;

    pdp8_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SNAP_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_cap),
        .i_pop   (w_pop),
        .i_wdata (w_snap),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_accept = (r_state == ST_EMIT) && tx.tx_ready;
    assign w_last   = (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_hold  <= w_head;
                    r_idx   <= '0;
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= w_empty ? ST_IDLE : ST_LOAD;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // A drop in the same cycle as clear_drops leaves the count at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else if (clear_drops) begin
            r_drop <= w_drop ? DROP_W'(1) : '0;
        end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    assign w_pc  = r_hold[PC_LSB +: 12];
    assign w_ir  = r_hold[IR_LSB +: 12];
    assign w_l   = r_hold[L_BIT];
    assign w_ac  = r_hold[AC_LSB +: 12];
    assign w_ion = r_hold[ION_BIT];

    always_comb begin
        w_char = CH_SP;
        case (r_idx)
            6'd0:            w_char = "p";
            6'd1:            w_char = "c";
            OFS_PC:          w_char = oct_char(w_pc[11:9]);
            OFS_PC + 6'd1:   w_char = oct_char(w_pc[8:6]);
            OFS_PC + 6'd2:   w_char = oct_char(w_pc[5:3]);
            OFS_PC + 6'd3:   w_char = oct_char(w_pc[2:0]);
            6'd8:            w_char = "i";
            6'd9:            w_char = "r";
            OFS_IR:          w_char = oct_char(w_ir[11:9]);
            OFS_IR + 6'd1:   w_char = oct_char(w_ir[8:6]);
            OFS_IR + 6'd2:   w_char = oct_char(w_ir[5:3]);
            OFS_IR + 6'd3:   w_char = oct_char(w_ir[2:0]);
            6'd16:           w_char = "l";
            OFS_L:           w_char = oct_char({2'b00, w_l});
            6'd20:           w_char = "a";
            6'd21:           w_char = "c";
            OFS_AC:          w_char = oct_char(w_ac[11:9]);
            OFS_AC + 6'd1:   w_char = oct_char(w_ac[8:6]);
            OFS_AC + 6'd2:   w_char = oct_char(w_ac[5:3]);
            OFS_AC + 6'd3:   w_char = oct_char(w_ac[2:0]);
            6'd28:           w_char = "i";
            6'd29:           w_char = "o";
            6'd30:           w_char = "n";
            OFS_ION:         w_char = oct_char({2'b00, w_ion});
            OFS_CR:          w_char = CH_CR;
            OFS_LF:          w_char = CH_LF;
            default:         w_char = CH_SP;
        endcase
    end

    assign tx.tx_valid = (r_state == ST_EMIT);
    assign tx.tx_data  = (r_state == ST_EMIT) ? w_char : 8'h00;
    assign drop_count  = r_drop;
    assign busy        = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_pdp8_trace.sv
module tb_pdp8_trace;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        fetch_strobe;
    logic [11:0] pc;
    logic [11:0] ir;
    logic        l;
    logic [11:0] ac;
    logic        ion;
    logic        clear_drops;
    logic [7:0]  drop_count;
    logic        busy;

    pdp8_trace_if tx_if ();

    pdp8_trace #(.DEPTH(16), .DROP_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fetch_strobe (fetch_strobe),
        .pc           (pc),
        .ir           (ir),
        .l            (l),
        .ac           (ac),
        .ion          (ion),
        .tx           (tx_if),
        .drop_count   (drop_count),
        .clear_drops  (clear_drops),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int lines_exp = 0;
    int lines_seen = 0;
    int chars_seen = 0;
    int ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    logic [7:0] exp_q [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] mon_exp;

    // Sole driver of tx_ready; updated shortly after every rising edge.
    initial begin
        tx_if.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                1:       tx_if.tx_ready = 1'b1;
                2:       tx_if.tx_ready = 1'($urandom_range(0, 1));
                default: tx_if.tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted character and checks
    // that a stalled character is held unchanged.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(tx_if.tx_valid && tx_if.tx_data == prev_data)) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b data=%h, required valid=1 data=%h",
                             tx_if.tx_valid, tx_if.tx_data, prev_data);
                end
            end
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                checks++;
                chars_seen++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_char: got %h, none expected", tx_if.tx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (tx_if.tx_data !== mon_exp) begin
                        errors++;
                        $display("FAIL char: got %h, required %h", tx_if.tx_data, mon_exp);
                    end
                    if (mon_exp == 8'h0A) lines_seen++;
                end
            end
            prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
            prev_data  = tx_if.tx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_line(input logic [11:0] p, input logic [11:0] i_, input logic l_,
                             input logic [11:0] a, input logic n_);
        string s;
        s = $sformatf("pc %04o ir %04o l %0d ac %04o ion %0d\r\n", p, i_, l_, a, n_);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
        lines_exp++;
    endtask

    // Called just after a rising edge; the strobe is sampled on the next edge.
    task automatic do_strobe(input logic [11:0] p, input logic [11:0] i_, input logic l_,
                             input logic [11:0] a, input logic n_, input bit accept);
        pc = p; ir = i_; l = l_; ac = a; ion = n_;
        fetch_strobe = 1'b1;
        if (accept && enable) push_line(p, i_, l_, a, n_);
        @(posedge clk);
        #1;
        fetch_strobe = 1'b0;
    endtask

    task automatic rand_strobe(input bit accept);
        do_strobe(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)),
                  1'($urandom_range(0, 1)), accept);
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_%s: still %0d chars pending, busy=%0b after %0d cycles",
                     tag, exp_q.size(), busy, n);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int n;
        reset_n = 1'b0; enable = 1'b1; fetch_strobe = 1'b0; clear_drops = 1'b0;
        pc = '0; ir = '0; l = 1'b0; ac = '0; ion = 1'b0;
        cycles(3);
        chk("reset_tx_valid", 32'(tx_if.tx_valid), 0);
        chk("reset_tx_data", 32'(tx_if.tx_data), 0);
        chk("reset_drop_count", 32'(drop_count), 0);
        chk("reset_busy", 32'(busy), 0);
        reset_n = 1'b1;
        cycles(2);

        // 1: single line, latency of first character
        ready_mode = 1;
        cycles(1);
        do_strobe(12'o0200, 12'o7300, 1'b0, 12'o0000, 1'b0, 1);
        @(negedge clk);
        chk("lat_n0_valid", 32'(tx_if.tx_valid), 0);
        chk("lat_n0_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_n1_valid", 32'(tx_if.tx_valid), 0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(tx_if.tx_valid), 1);
        chk("lat_n2_data", 32'(tx_if.tx_data), 32'h70);
        @(posedge clk); #1;
        drain(200, "t1");
        chk("t1_lines", lines_seen, lines_exp);

        // 2: random ready, fixed line then random bursts
        ready_mode = 2;
        do_strobe(12'o7777, 12'o5177, 1'b1, 12'o4321, 1'b1, 1);
        drain(1000, "t2a");
        for (int b = 0; b < 3; b++) begin
            n = $urandom_range(1, 16);
            for (int k = 0; k < n; k++) begin
                rand_strobe(1);
                cycles($urandom_range(0, 3));
            end
            drain(6000, "t2b");
        end
        chk("t2_drops", 32'(drop_count), 0);
        chk("t2_lines", lines_seen, lines_exp);

        // 3: overflow with ready low, then clear, then push+pop while full
        ready_mode = 0;
        cycles(3);
        rand_strobe(1);
        cycles(4);
        for (int k = 0; k < 20; k++) rand_strobe(k < 16);
        @(negedge clk);
        chk("t3_drops", 32'(drop_count), 4);
        @(posedge clk); #1;
        clear_drops = 1'b1;
        cycles(1);
        clear_drops = 1'b0;
        @(negedge clk);
        chk("t3_cleared", 32'(drop_count), 0);
        @(posedge clk); #1;
        ready_mode = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tx_if.tx_valid && tx_if.tx_ready && tx_if.tx_data == 8'h0A) && n < 200);
        chk("t3_lf_timeout", 32'(n < 200), 1);
        @(posedge clk); #1;
        rand_strobe(1);
        @(negedge clk);
        chk("t6_full_pushpop_drops", 32'(drop_count), 0);
        @(posedge clk); #1;
        drain(2000, "t3");
        chk("t3_lines", lines_seen, lines_exp);

        // 4: saturation, clear together with a drop
        ready_mode = 0;
        cycles(3);
        rand_strobe(1);
        cycles(4);
        for (int k = 0; k < 16; k++) rand_strobe(1);
        for (int k = 0; k < 300; k++) rand_strobe(0);
        @(negedge clk);
        chk("t4_saturate", 32'(drop_count), 255);
        @(posedge clk); #1;
        clear_drops = 1'b1;
        rand_strobe(0);
        clear_drops = 1'b0;
        @(negedge clk);
        chk("t4_clear_with_drop", 32'(drop_count), 1);
        @(posedge clk); #1;
        rand_strobe(0);
        rand_strobe(0);
        @(negedge clk);
        chk("t4_after_clear", 32'(drop_count), 3);
        @(posedge clk); #1;

        // 5: reset in the middle of a line
        ready_mode = 1;
        base = chars_seen;
        n = 0;
        while (chars_seen < base + 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_char10", 32'(n < 500), 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(tx_if.tx_valid), 0);
        chk("t5_rst_data", 32'(tx_if.tx_data), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_drops", 32'(drop_count), 0);
        exp_q.delete();
        lines_exp = lines_seen;
        cycles(3);
        reset_n = 1'b1;
        cycles(40);
        chk("t5_quiet_valid", 32'(tx_if.tx_valid), 0);
        chk("t5_quiet_busy", 32'(busy), 0);
        do_strobe(12'o1234, 12'o4567, 1'b1, 12'o0007, 1'b0, 1);
        drain(200, "t5");
        chk("t5_lines", lines_seen, lines_exp);

        // 6: enable low blocks capture
        enable = 1'b0;
        for (int k = 0; k < 10; k++) rand_strobe(1);
        cycles(5);
        chk("t6_disabled_busy", 32'(busy), 0);
        chk("t6_disabled_drops", 32'(drop_count), 0);
        enable = 1'b1;
        cycles(5);
        chk("final_lines", lines_seen, lines_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
